// File: rtl/host_read_port.sv
// Host-side Avalon-MM read port draining a fabric-fed circular queue with a prefetched head word.
// Define HOST_RD_PKTCNT_EN to build the popped-word counter at address 4 (otherwise it reads 0).

module host_read_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              read,
   input  logic [3:0]        address,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              empty
);

   localparam int              DEPTH      = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] head_q;
   logic              overflow_q, underflow_q;
   logic              rd_req, accept, pop_ok, pop_empty, push_ok, stat_clr;
   logic [31:0]       status_word, rd_mux;
`ifdef HOST_RD_PKTCNT_EN
   logic [31:0]       pktcnt_q;
`endif

   assign full        = (count_q == FULL_COUNT);
   assign empty       = (count_q == '0);
   assign push_ok     = wr_en & ~full;
   assign status_word = {12'b0, underflow_q, overflow_q, full, empty, 3'b0, 13'(count_q)};

   // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_EMPTY: if (count_q != '0) state_d = S_FETCH;
         S_FETCH: state_d = S_READY;
         S_READY: if (pop_ok) state_d = (count_q > CNT_ONE) ? S_FETCH : S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      rd_req      = chipselect & read;
      waitrequest = rd_req & (address == 4'd0) & (state_q == S_FETCH);
      accept      = rd_req & ~waitrequest;
      pop_ok      = accept & (address == 4'd0) & (state_q == S_READY);
      pop_empty   = accept & (address == 4'd0) & (state_q == S_EMPTY);
      stat_clr    = accept & (address == 4'd3);
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         4'd0, 4'd2: if (state_q == S_READY) rd_mux = 32'(head_q);
         4'd1, 4'd3: rd_mux = status_word;
`ifdef HOST_RD_PKTCNT_EN
         4'd4:       rd_mux = pktcnt_q;
`endif
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         readdata    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (accept) readdata <= rd_mux;
         // a sticky event landing in the same cycle as STATCLR survives the clear
         overflow_q  <= (overflow_q & ~stat_clr) | (wr_en & full);
         underflow_q <= (underflow_q & ~stat_clr) | pop_empty;
      end
   end

   // NOTE: the RAM is not reset; stale words are unreachable because pointers and count are.
   always_ff @(posedge clk) begin
      if (push_ok)              mem[wr_ptr_q] <= wr_data;
      if (state_q == S_FETCH)   head_q        <= mem[rd_ptr_q];
   end

`ifdef HOST_RD_PKTCNT_EN
   always_ff @(posedge clk) begin
      if (!reset || stat_clr) pktcnt_q <= '0;
      else if (pop_ok)        pktcnt_q <= pktcnt_q + 32'd1;
   end
`endif

endmodule

// File: tb/tb_host_read_port.sv
// Self-checking bench for host_read_port (ADDR_W=2): table-driven bus traffic with a popped-word
// scoreboard, plus hand sequences for full-flag and reset-mid-fetch corners.

module tb_host_read_port;

   localparam int ADDR_W       = 2;
   localparam int DEPTH        = 4;
   localparam int STALL_BUDGET = 8;
`ifdef HOST_RD_PKTCNT_EN
   localparam logic [31:0] PKTCNT7 = 32'd7;
`else
   localparam logic [31:0] PKTCNT7 = 32'd0;
`endif

   logic        clk;
   logic        reset;
   logic        chipselect;
   logic        read;
   logic [3:0]  address;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        full;
   logic        empty;

   host_read_port #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (chipselect),
      .read        (read),
      .address     (address),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum logic [1:0] {OP_PUSH, OP_READ, OP_POP, OP_POPPUSH} op_e;
   typedef struct {
      op_e         op;
      logic [3:0]  addr;
      logic [31:0] data;       // push word, or expected readdata for OP_READ
      int          exp_stall;  // -1: stall count not checked
      string       name;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   int          model_count = 0;
   int          n_pass = 0;
   int          n_total = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_total++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input op_e op, input logic [3:0] addr, input logic [31:0] data,
                      input int exp_stall, input string name);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.exp_stall = exp_stall; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data, output int stalls,
                           input logic push_en, input logic [31:0] push_data);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = addr;
      stalls     = 0;
      #1;
      while (waitrequest && stalls < STALL_BUDGET) begin
         stalls++;
         tick();
      end
      if (waitrequest) begin
         n_total++;
         $display("FAIL waitrequest_bound: still stalled after %0d cycles, required release", stalls);
      end
      wr_en   = push_en;
      wr_data = push_data;
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
      wr_en      = 1'b0;
      address    = 4'd0;
      data       = readdata;
   endtask

   task automatic do_push(input logic [31:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
      if (model_count < DEPTH) begin
         sb.push_back(w);
         model_count++;
      end
   endtask

   // A push alongside the pop is judged against the pre-pop occupancy.
   task automatic do_pop(input string name, input int exp_stall, input logic push_en,
                         input logic [31:0] push_data);
      logic [31:0] got;
      logic [31:0] exp;
      int          stalls;
      int          pre;
      pre = model_count;
      bus_read(4'd0, got, stalls, push_en, push_data);
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         model_count--;
      end else begin
         exp = 32'd0;
      end
      if (push_en && pre < DEPTH) begin
         sb.push_back(push_data);
         model_count++;
      end
      check(name, got, exp);
      if (exp_stall >= 0) check({name, "_stall"}, 32'(stalls), 32'(exp_stall));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          stalls;

      // basic ordering and back-to-back stall
      add(OP_READ, 4'd1, 32'h0001_0000, -1, "a_status_reset");
      add(OP_PUSH, 4'd0, 32'hA5A5_0001, -1, "a_push1");
      add(OP_PUSH, 4'd0, 32'hA5A5_0002, -1, "a_push2");
      add(OP_PUSH, 4'd0, 32'hA5A5_0003, -1, "a_push3");
      add(OP_POP,  4'd0, 32'h0, 0, "a_pop1");
      add(OP_POP,  4'd0, 32'h0, 1, "a_pop2");
      add(OP_POP,  4'd0, 32'h0, 1, "a_pop3");
      add(OP_READ, 4'd1, 32'h0001_0000, -1, "a_status_drained");
      add(OP_READ, 4'd2, 32'h0000_0000, -1, "a_peek_empty");
      // fill past capacity, sticky overflow and STATCLR
      for (int i = 0; i < 5; i++) add(OP_PUSH, 4'd0, 32'hB000_0000 + 32'(i), -1, "b_push");
      add(OP_READ, 4'd1, 32'h0006_0004, -1, "b_status_full");
      add(OP_READ, 4'd3, 32'h0006_0004, -1, "b_statclr");
      add(OP_READ, 4'd1, 32'h0002_0004, -1, "b_status_after_clr");
      add(OP_READ, 4'd2, 32'hB000_0000, -1, "b_peek");
      add(OP_POP,  4'd0, 32'h0, 0, "b_pop1");
      for (int i = 0; i < 3; i++) add(OP_POP, 4'd0, 32'h0, 1, "b_pop");
      add(OP_READ, 4'd1, 32'h0001_0000, -1, "b_status_drained");
      // underflow with concurrent push
      add(OP_POPPUSH, 4'd0, 32'h0000_1234, 0, "c_pop_empty");
      add(OP_READ, 4'd1, 32'h0008_0001, -1, "c_status_underflow");
      add(OP_POP,  4'd0, 32'h0, 1, "c_pop_1234");
      add(OP_READ, 4'd3, 32'h0009_0000, -1, "c_statclr");
      add(OP_READ, 4'd1, 32'h0001_0000, -1, "c_status_clean");
      // pop and push while full, then interleaved traffic across the pointer wrap
      for (int i = 0; i < 4; i++) add(OP_PUSH, 4'd0, 32'hC000_0000 + 32'(i), -1, "d_push");
      add(OP_POPPUSH, 4'd0, 32'hC000_0004, 0, "d_pop_push_full");
      add(OP_READ, 4'd1, 32'h0004_0003, -1, "d_status_ovf");
      add(OP_READ, 4'd3, 32'h0004_0003, -1, "d_statclr");
      for (int i = 0; i < 4; i++) begin
         add(OP_POP,  4'd0, 32'h0, -1, "d_wrap_pop");
         add(OP_PUSH, 4'd0, 32'hD000_0000 + 32'(i), -1, "d_wrap_push");
      end
      for (int i = 0; i < 3; i++) add(OP_POP, 4'd0, 32'h0, -1, "d_drain_pop");
      add(OP_READ, 4'd1, 32'h0001_0000, -1, "d_status_drained");
      add(OP_READ, 4'd5, 32'h0000_0000, -1, "d_unmapped5");
      add(OP_READ, 4'd15, 32'h0000_0000, -1, "d_unmapped15");
      // popped-word counter
      add(OP_READ, 4'd3, 32'h0001_0000, -1, "e_statclr_pre");
      for (int i = 0; i < 4; i++) add(OP_PUSH, 4'd0, 32'hE000_0000 + 32'(i), -1, "e_push");
      for (int i = 0; i < 4; i++) add(OP_POP, 4'd0, 32'h0, -1, "e_pop");
      for (int i = 4; i < 7; i++) add(OP_PUSH, 4'd0, 32'hE000_0000 + 32'(i), -1, "e_push");
      for (int i = 0; i < 3; i++) add(OP_POP, 4'd0, 32'h0, -1, "e_pop");
      add(OP_READ, 4'd4, PKTCNT7, -1, "e_pktcnt");
      add(OP_READ, 4'd3, 32'h0001_0000, -1, "e_statclr");
      add(OP_READ, 4'd4, 32'h0000_0000, -1, "e_pktcnt_cleared");

      chipselect = 1'b0;
      read       = 1'b0;
      address    = 4'd0;
      wr_en      = 1'b0;
      wr_data    = 32'd0;
      reset      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check("rst_readdata", readdata, 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_waitrequest", 32'(waitrequest), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_PUSH:    do_push(vecs[i].data);
            OP_READ: begin
               bus_read(vecs[i].addr, got, stalls, 1'b0, 32'd0);
               check(vecs[i].name, got, vecs[i].data);
            end
            OP_POP:     do_pop(vecs[i].name, vecs[i].exp_stall, 1'b0, 32'd0);
            OP_POPPUSH: do_pop(vecs[i].name, vecs[i].exp_stall, 1'b1, vecs[i].data);
            default: ;
         endcase
      end

      // full flag and reset discarding queued words
      for (int i = 0; i < 4; i++) do_push(32'hF000_0000 + 32'(i));
      check("h_full_pin", 32'(full), 32'd1);
      check("h_empty_pin_full", 32'(empty), 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      sb.delete();
      model_count = 0;
      check("h_reset_discards_empty", 32'(empty), 32'd1);
      check("h_reset_discards_full", 32'(full), 32'd0);

      // reset asserted while the head fetch is in flight
      do_push(32'hF1F1_0000);
      tick();
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 4'd0;
      #1;
      check("r_stall_in_fetch", 32'(waitrequest), 32'd1);
      reset = 1'b0;
      tick();
      check("r_empty_after_reset", 32'(empty), 32'd1);
      check("r_wait_after_reset", 32'(waitrequest), 32'd0);
      chipselect = 1'b0;
      read       = 1'b0;
      reset      = 1'b1;
      sb.delete();
      model_count = 0;
      check("r_readdata_after_reset", readdata, 32'd0);
      bus_read(4'd1, got, stalls, 1'b0, 32'd0);
      check("r_status_after_reset", got, 32'h0001_0000);
      bus_read(4'd4, got, stalls, 1'b0, 32'd0);
      check("r_pktcnt_after_reset", got, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
